axi_stream_header_arbiter: RTL and testbench
============================================

// Module: axi_stream_header_arbiter
// PURPOSE
//   Packet-level round-robin arbiter sharing one axi_stream_insert_header datapath between NUM_REQ
//   requesters. Each requester presents a header (insert channel) plus a payload stream.
//   The arbiter grants one requester and forwards its header beat and whole payload packet
//   (through last_in) to the downstream insert block. It then releases the grant and re-arbitrates.
// PARAMETERS
//   DATA_WD       32                  payload/header data width, bits (multiple of 8)
//   DATA_BYTE_WD  DATA_WD/8           keep width
//   BYTE_CNT_WD   $clog2(DATA_BYTE_WD) byte_insert_cnt width
//   NUM_REQ       2                   requester count, >=2
//   ID_WD         $clog2(NUM_REQ)     grant index width
// PORTS (per-requester buses flattened, requester i at slice [i*W +: W])
//   clk                 in   1                    clock, all logic on rising edge
//   rst                 in   1                    asynchronous reset, active-high
//   s_valid_in          in   NUM_REQ              payload valid per requester
//   s_data_in           in   NUM_REQ*DATA_WD      payload data
//   s_keep_in           in   NUM_REQ*DATA_BYTE_WD payload byte keep
//   s_last_in           in   NUM_REQ              payload last beat
//   s_ready_in          out  NUM_REQ              payload ready
//   s_valid_insert      in   NUM_REQ              header valid; this is the arbitration request
//   s_data_insert       in   NUM_REQ*DATA_WD      header data
//   s_keep_insert       in   NUM_REQ*DATA_BYTE_WD header keep
//   s_byte_insert_cnt   in   NUM_REQ*BYTE_CNT_WD  header byte count
//   s_ready_insert      out  NUM_REQ              header ready
//   m_valid_in / m_data_in / m_keep_in / m_last_in  out  1/DATA_WD/DATA_BYTE_WD/1  payload to insert block
//   m_ready_in          in   1                    payload ready from insert block
//   m_valid_insert / m_data_insert / m_keep_insert / m_byte_insert_cnt  out  header to insert block
//   m_ready_insert      in   1                    header ready from insert block
//   grant_valid         out  1                    a requester currently owns the datapath
//   grant_id            out  ID_WD                index of the owning requester
// BEHAVIOUR
//   - State: IDLE / ACTIVE (registered), with flags hdr_done, body_done and ptr (last granted id).
//   - Reset: state=IDLE, hdr_done=body_done=0, ptr=NUM_REQ-1, grant_valid=0, grant_id=0.
//     All m_valid_*, s_ready_* are 0 and m_* data is 0 (muxed through grant_valid).
//   - Reset mid-packet: the packet is abandoned immediately. The downstream insert block is reset
//     by the same rst.
//   - IDLE: if any s_valid_insert is set, pick the first set bit searching ptr+1, ptr+2, ...
//     (modulo NUM_REQ). Next edge: ACTIVE, grant_id=pick, ptr=pick, flags cleared.
//     Grant latency is 1 cycle; there are no handshakes in IDLE.
//   - ACTIVE header path (while !hdr_done): m_*_insert = granted s_*_insert;
//     s_ready_insert[g] = m_ready_insert. hdr_done sets on the m_valid_insert & m_ready_insert edge.
//   - ACTIVE payload path (while !body_done): m_*_in = granted s_*_in; s_ready_in[g] = m_ready_in.
//     body_done sets on the edge where m_valid_in & m_ready_in & m_last_in.
//   - Header and payload proceed concurrently and independently; either may finish first.
//   - Return to IDLE on the edge where both flags are (or become) done, including both in the same cycle.
//     This gives one bubble cycle between packets.
//   - Non-granted requesters: s_ready_* = 0, never stalled-with-data-loss. Their valid/data must
//     be held (AXI rule); this block does not check it.
//   - Pure combinational forward on data/valid/ready in ACTIVE: no extra latency, no buffering.
//     The m_ready->s_ready path is combinational.
//   - Round-robin fairness: with all requesters continuously requesting, grants cycle 0,1,..,NUM_REQ-1,0...
//   - Payload beats from the granted requester before its header is accepted are forwarded as-is.
//     Ordering is the insert block's job.
// TESTING
//   1 Reset then idle: all m_valid_*=0, s_ready_*=0, grant_valid=0 for 10 cycles.
//   2 Only req0 requests: header 0xA5A5A5A5 cnt=2, 3-beat packet. Expect grant_id=0 one cycle after
//     valid_insert; 3 m beats matching input; IDLE after last; ready_in[1] stays 0.
//   3 Both requesters continuously request 4 packets each: grant sequence 0,1,0,1,...;
//     no beat from the non-granted requester appears on m_*.
//   4 Header accepted 5 cycles after payload last (m_ready_insert held low): grant held until
//     header handshake, then IDLE next edge.
//   5 Random m_ready_in/m_ready_insert backpressure (80% high), 100 packets, random lengths 1-6:
//     scoreboard per-requester byte streams and headers match exactly.
//   6 Assert rst during beat 2 of a 4-beat packet: all outputs 0 asynchronously.
//     After release, the next request is granted from ptr reset value (req0 first).

Source files
------------

// File: rtl/axi_stream_header_arbiter.sv
// Packet-level round-robin arbiter in front of one header-insert datapath.
// The granted requester's header beat and payload packet are forwarded
// combinationally. The grant is released once both have completed.
module axi_stream_header_arbiter #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
   parameter int NUM_REQ      = 2,
   parameter int ID_WD        = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              s_valid_in,
   input  logic [NUM_REQ*DATA_WD-1:0]      s_data_in,
   input  logic [NUM_REQ*DATA_BYTE_WD-1:0] s_keep_in,
   input  logic [NUM_REQ-1:0]              s_last_in,
   output logic [NUM_REQ-1:0]              s_ready_in,
   input  logic [NUM_REQ-1:0]              s_valid_insert,
   input  logic [NUM_REQ*DATA_WD-1:0]      s_data_insert,
   input  logic [NUM_REQ*DATA_BYTE_WD-1:0] s_keep_insert,
   input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  s_byte_insert_cnt,
   output logic [NUM_REQ-1:0]              s_ready_insert,
   output logic                            m_valid_in,
   output logic [DATA_WD-1:0]              m_data_in,
   output logic [DATA_BYTE_WD-1:0]         m_keep_in,
   output logic                            m_last_in,
   input  logic                            m_ready_in,
   output logic                            m_valid_insert,
   output logic [DATA_WD-1:0]              m_data_insert,
   output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
   output logic [BYTE_CNT_WD-1:0]          m_byte_insert_cnt,
   input  logic                            m_ready_insert,
   output logic                            grant_valid,
   output logic [ID_WD-1:0]                grant_id
);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   state_t           r_state, w_state_next;
   logic             r_hdr_done, w_hdr_done_next;
   logic             r_body_done, w_body_done_next;
   logic [ID_WD-1:0] r_ptr, w_ptr_next;
   logic [ID_WD-1:0] r_grant_id, w_grant_id_next;
   logic             w_pick_found;
   logic [ID_WD-1:0] w_pick_id;
   logic [ID_WD-1:0] w_idx;
   logic             w_hdr_act, w_body_act;
   logic             w_hdr_fire, w_last_fire;

   assign grant_valid = (r_state == ST_ACTIVE);
   assign grant_id    = r_grant_id;
   assign w_hdr_act   = grant_valid & ~r_hdr_done;
   assign w_body_act  = grant_valid & ~r_body_done;
   assign w_hdr_fire  = m_valid_insert & m_ready_insert;
   assign w_last_fire = m_valid_in & m_ready_in & m_last_in;

   // Round-robin search: walk from the farthest candidate back to ptr+1 so the
   // nearest requesting index after the last grant is written last and wins.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_id    = '0;
      w_idx        = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_idx = ID_WD'((int'(r_ptr) + k) % NUM_REQ);
         if (s_valid_insert[w_idx]) begin
            w_pick_found = 1'b1;
            w_pick_id    = w_idx;
         end
      end
   end

   // Header path: the granted requester's header reaches the insert block until it is accepted.
   always_comb begin
      m_valid_insert    = 1'b0;
      m_data_insert     = '0;
      m_keep_insert     = '0;
      m_byte_insert_cnt = '0;
      s_ready_insert    = '0;
      if (w_hdr_act) begin
         m_valid_insert              = s_valid_insert[r_grant_id];
         m_data_insert               = s_data_insert[r_grant_id*DATA_WD +: DATA_WD];
         m_keep_insert               = s_keep_insert[r_grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
         m_byte_insert_cnt           = s_byte_insert_cnt[r_grant_id*BYTE_CNT_WD +: BYTE_CNT_WD];
         s_ready_insert[r_grant_id]  = m_ready_insert;
      end
   end

   // Payload path: the granted requester's beats pass through until its last beat is accepted.
   always_comb begin
      m_valid_in  = 1'b0;
      m_data_in   = '0;
      m_keep_in   = '0;
      m_last_in   = 1'b0;
      s_ready_in  = '0;
      if (w_body_act) begin
         m_valid_in             = s_valid_in[r_grant_id];
         m_data_in              = s_data_in[r_grant_id*DATA_WD +: DATA_WD];
         m_keep_in              = s_keep_in[r_grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
         m_last_in              = s_last_in[r_grant_id];
         s_ready_in[r_grant_id] = m_ready_in;
      end
   end

   // Next-state: grant in IDLE, track header/payload completion in ACTIVE.
   always_comb begin
      w_state_next     = r_state;
      w_hdr_done_next  = r_hdr_done;
      w_body_done_next = r_body_done;
      w_ptr_next       = r_ptr;
      w_grant_id_next  = r_grant_id;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_found) begin
               w_state_next     = ST_ACTIVE;
               w_grant_id_next  = w_pick_id;
               w_ptr_next       = w_pick_id;
               w_hdr_done_next  = 1'b0;
               w_body_done_next = 1'b0;
            end
         end
         ST_ACTIVE: begin
            w_hdr_done_next  = r_hdr_done | w_hdr_fire;
            w_body_done_next = r_body_done | w_last_fire;
            if (w_hdr_done_next & w_body_done_next) begin
               w_state_next     = ST_IDLE;
               w_hdr_done_next  = 1'b0;
               w_body_done_next = 1'b0;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State registers; reset abandons any packet in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_hdr_done  <= 1'b0;
         r_body_done <= 1'b0;
         r_ptr       <= ID_WD'(NUM_REQ - 1);
         r_grant_id  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_hdr_done  <= w_hdr_done_next;
         r_body_done <= w_body_done_next;
         r_ptr       <= w_ptr_next;
         r_grant_id  <= w_grant_id_next;
      end
   end

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Randomized bench for axi_stream_header_arbiter with a packet-level
// round-robin reference model and per-requester scoreboards.
module tb_axi_stream_header_arbiter;

   localparam int DW   = 32;
   localparam int BW   = DW / 8;
   localparam int CW   = 2;
   localparam int NR   = 2;
   localparam int IW   = 1;
   localparam int MAXP = 80;
   localparam int MAXB = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     s_valid_in, s_last_in, s_ready_in;
   logic [NR*DW-1:0]  s_data_in;
   logic [NR*BW-1:0]  s_keep_in;
   logic [NR-1:0]     s_valid_insert, s_ready_insert;
   logic [NR*DW-1:0]  s_data_insert;
   logic [NR*BW-1:0]  s_keep_insert;
   logic [NR*CW-1:0]  s_byte_insert_cnt;
   logic              m_valid_in, m_last_in, m_ready_in;
   logic [DW-1:0]     m_data_in;
   logic [BW-1:0]     m_keep_in;
   logic              m_valid_insert, m_ready_insert;
   logic [DW-1:0]     m_data_insert;
   logic [BW-1:0]     m_keep_insert;
   logic [CW-1:0]     m_byte_insert_cnt;
   logic              grant_valid;
   logic [IW-1:0]     grant_id;

   axi_stream_header_arbiter #(.DATA_WD(DW), .NUM_REQ(NR)) dut (
      .clk(clk), .rst(rst),
      .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
      .s_last_in(s_last_in), .s_ready_in(s_ready_in),
      .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert),
      .s_keep_insert(s_keep_insert), .s_byte_insert_cnt(s_byte_insert_cnt),
      .s_ready_insert(s_ready_insert),
      .m_valid_in(m_valid_in), .m_data_in(m_data_in), .m_keep_in(m_keep_in),
      .m_last_in(m_last_in), .m_ready_in(m_ready_in),
      .m_valid_insert(m_valid_insert), .m_data_insert(m_data_insert),
      .m_keep_insert(m_keep_insert), .m_byte_insert_cnt(m_byte_insert_cnt),
      .m_ready_insert(m_ready_insert),
      .grant_valid(grant_valid), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // stimulus / expected-packet store
   logic [DW-1:0] hdr_d [NR][MAXP];
   logic [BW-1:0] hdr_k [NR][MAXP];
   logic [CW-1:0] hdr_c [NR][MAXP];
   int            plen  [NR][MAXP];
   logic [DW-1:0] bd    [NR][MAXP][MAXB];
   logic [BW-1:0] bk    [NR][MAXP][MAXB];
   int            npkt [NR];
   int            drv_pkt [NR];
   int            drv_beat [NR];
   bit            drv_hdr [NR];

   // packet-level reference model
   bit mdl_busy, mdl_hs, mdl_bs;
   int mdl_owner, mdl_ptr, mdl_beat;
   int mdl_pkt [NR];
   int rdy_pct;
   bit hold_hdr;
   int since_body;
   int first_dut_grant;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add_pkt(input int r, input int len, input logic [DW-1:0] h, input logic [CW-1:0] c);
      int p;
      p = npkt[r];
      hdr_d[r][p] = h;
      hdr_k[r][p] = BW'($urandom);
      hdr_c[r][p] = c;
      plen[r][p]  = len;
      for (int b = 0; b < len; b++) begin
         bd[r][p][b] = $urandom;
         bk[r][p][b] = (b == len - 1) ? BW'($urandom_range(1, 15)) : {BW{1'b1}};
      end
      npkt[r] = p + 1;
   endtask

   task automatic drive();
      int p, b;
      bit act;
      for (int r = 0; r < NR; r++) begin
         act = drv_pkt[r] < npkt[r];
         p   = act ? drv_pkt[r] : 0;
         b   = (act && drv_beat[r] < plen[r][p]) ? drv_beat[r] : 0;
         s_valid_insert[r]               = act && !drv_hdr[r];
         s_data_insert[r*DW +: DW]       = act ? hdr_d[r][p] : '0;
         s_keep_insert[r*BW +: BW]       = act ? hdr_k[r][p] : '0;
         s_byte_insert_cnt[r*CW +: CW]   = act ? hdr_c[r][p] : '0;
         s_valid_in[r]                   = act && drv_beat[r] < plen[r][p];
         s_data_in[r*DW +: DW]           = act ? bd[r][p][b] : '0;
         s_keep_in[r*BW +: BW]           = act ? bk[r][p][b] : '0;
         s_last_in[r]                    = act && (drv_beat[r] == plen[r][p] - 1);
      end
      m_ready_in     = ($urandom_range(0, 99) < rdy_pct);
      m_ready_insert = hold_hdr ? (mdl_bs && since_body >= 5) : ($urandom_range(0, 99) < rdy_pct);
   endtask

   // one clock: check at negedge, advance model, then update drivers after posedge
   task automatic step();
      logic [NR-1:0] er, fh, fi;
      bit was_busy, hf, inf;
      int p, rr;
      @(negedge clk);
      if (mdl_busy && mdl_bs) since_body++;
      if (mdl_busy) begin
         chk("grant_valid", 64'(grant_valid), 64'(1));
         chk("grant_id", 64'(grant_id), 64'(mdl_owner));
      end else begin
         chk("grant_valid", 64'(grant_valid), 64'(0));
         chk("m_data_in_idle", 64'(m_data_in), 64'(0));
      end
      if (grant_valid && first_dut_grant < 0) first_dut_grant = int'(grant_id);
      chk("m_valid_insert", 64'(m_valid_insert), 64'(mdl_busy && !mdl_hs));
      chk("m_valid_in", 64'(m_valid_in), 64'(mdl_busy && !mdl_bs));
      er = '0;
      if (mdl_busy && !mdl_hs) er[mdl_owner] = m_ready_insert;
      chk("s_ready_insert", 64'(s_ready_insert), 64'(er));
      er = '0;
      if (mdl_busy && !mdl_bs) er[mdl_owner] = m_ready_in;
      chk("s_ready_in", 64'(s_ready_in), 64'(er));
      hf  = m_valid_insert && m_ready_insert;
      inf = m_valid_in && m_ready_in;
      fh  = s_valid_insert & s_ready_insert;
      fi  = s_valid_in & s_ready_in;
      was_busy = mdl_busy;
      if (mdl_busy) begin
         p = mdl_pkt[mdl_owner];
         if (hf) begin
            chk("hdr_data", 64'(m_data_insert), 64'(hdr_d[mdl_owner][p]));
            chk("hdr_keep", 64'(m_keep_insert), 64'(hdr_k[mdl_owner][p]));
            chk("hdr_cnt", 64'(m_byte_insert_cnt), 64'(hdr_c[mdl_owner][p]));
            mdl_hs = 1'b1;
         end
         if (inf) begin
            if (mdl_beat < plen[mdl_owner][p]) begin
               chk("beat_data", 64'(m_data_in), 64'(bd[mdl_owner][p][mdl_beat]));
               chk("beat_keep", 64'(m_keep_in), 64'(bk[mdl_owner][p][mdl_beat]));
               chk("beat_last", 64'(m_last_in), 64'(mdl_beat == plen[mdl_owner][p] - 1));
               if (mdl_beat == plen[mdl_owner][p] - 1) begin
                  mdl_bs     = 1'b1;
                  since_body = 0;
               end
               mdl_beat++;
            end else begin
               chk("extra_beat", 64'(1), 64'(0));
            end
         end
         if (mdl_hs && mdl_bs) begin
            mdl_busy = 1'b0;
            mdl_pkt[mdl_owner]++;
         end
      end
      if (!was_busy) begin
         for (int k = 1; k <= NR && !mdl_busy; k++) begin
            rr = (mdl_ptr + k) % NR;
            if (drv_pkt[rr] < npkt[rr]) begin
               mdl_busy  = 1'b1;
               mdl_owner = rr;
               mdl_ptr   = rr;
               mdl_hs    = 1'b0;
               mdl_bs    = 1'b0;
               mdl_beat  = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
         if (fh[r]) drv_hdr[r] = 1'b1;
         if (fi[r]) drv_beat[r]++;
         if (drv_pkt[r] < npkt[r] && drv_hdr[r] && drv_beat[r] >= plen[r][drv_pkt[r]]) begin
            drv_pkt[r]++;
            drv_hdr[r]  = 1'b0;
            drv_beat[r] = 0;
         end
      end
      drive();
   endtask

   task automatic run_drain(input string tag, input int budget);
      int c;
      bit done;
      c = 0;
      done = 1'b0;
      while (!done && c < budget) begin
         step();
         c++;
         done = !mdl_busy;
         for (int r = 0; r < NR; r++) if (drv_pkt[r] != npkt[r]) done = 1'b0;
      end
      chk(tag, 64'(done), 64'(1));
   endtask

   task automatic clear_state();
      for (int r = 0; r < NR; r++) begin
         drv_pkt[r]  = npkt[r];
         mdl_pkt[r]  = npkt[r];
         drv_hdr[r]  = 1'b0;
         drv_beat[r] = 0;
      end
      mdl_busy = 1'b0;
      mdl_hs   = 1'b0;
      mdl_bs   = 1'b0;
      mdl_beat = 0;
      mdl_ptr  = NR - 1;
   endtask

   initial begin
      int c;
      rst = 1'b1;
      rdy_pct = 100;
      hold_hdr = 1'b0;
      since_body = 0;
      first_dut_grant = -1;
      mdl_owner = 0;
      for (int r = 0; r < NR; r++) npkt[r] = 0;
      clear_state();
      drive();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // idle after reset
      repeat (10) step();

      // single requester, fixed header, 3 beats
      add_pkt(0, 3, 32'hA5A5A5A5, 2'd2);
      drive();
      run_drain("drain_single", 40);
      chk("single_first_grant", 64'(first_dut_grant), 64'(0));

      // both requesters, four packets each, no backpressure
      for (int i = 0; i < 4; i++) begin
         add_pkt(0, $urandom_range(1, 4), $urandom, CW'($urandom));
         add_pkt(1, $urandom_range(1, 4), $urandom, CW'($urandom));
      end
      drive();
      run_drain("drain_both", 200);

      // header held off until well after the payload's last beat
      hold_hdr = 1'b1;
      add_pkt(1, 3, $urandom, CW'($urandom));
      drive();
      run_drain("drain_late_hdr", 60);
      hold_hdr = 1'b0;

      // random lengths under 80% backpressure
      rdy_pct = 80;
      for (int i = 0; i < 50; i++) begin
         add_pkt(0, $urandom_range(1, MAXB), $urandom, CW'($urandom));
         add_pkt(1, $urandom_range(1, MAXB), $urandom, CW'($urandom));
      end
      drive();
      run_drain("drain_random", 6000);

      // reset in the middle of a 4-beat packet
      rdy_pct = 100;
      add_pkt(1, 4, $urandom, CW'($urandom));
      drive();
      c = 0;
      while (!(mdl_busy && mdl_beat == 1) && c < 20) begin
         step();
         c++;
      end
      chk("reach_beat2", 64'(mdl_busy && mdl_beat == 1), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("rst_grant_valid", 64'(grant_valid), 64'(0));
      chk("rst_m_valid_in", 64'(m_valid_in), 64'(0));
      chk("rst_m_valid_insert", 64'(m_valid_insert), 64'(0));
      chk("rst_m_data_in", 64'(m_data_in), 64'(0));
      chk("rst_s_ready_in", 64'(s_ready_in), 64'(0));
      chk("rst_s_ready_insert", 64'(s_ready_insert), 64'(0));
      clear_state();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      first_dut_grant = -1;
      add_pkt(0, 2, $urandom, CW'($urandom));
      add_pkt(1, 2, $urandom, CW'($urandom));
      drive();
      run_drain("drain_after_rst", 60);
      chk("rst_first_grant", 64'(first_dut_grant), 64'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
